// File: rtl/graph_update_ctrl.sv
// Double-buffered graph store: shadow point/tour arrays are written through
// handshakes and copied to the display arrays one entry per cycle during vblank.
module graph_update_ctrl #(
  parameter int N = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vsync_start,
  input  logic               commit,
  input  logic               pt_valid,
  output logic               pt_ready,
  input  logic [5:0]         pt_idx,
  input  logic [7:0]         pt_x,
  input  logic [7:0]         pt_y,
  input  logic               path_valid,
  output logic               path_ready,
  input  logic [5:0]         path_pos,
  input  logic [5:0]         path_node,
  output logic [N-1:0][7:0]  xs,
  output logic [N-1:0][7:0]  ys,
  output logic [N-1:0][5:0]  path,
  output logic               busy,
  output logic               done,
  output logic [15:0]        frame_cnt
);

  typedef enum logic [1:0] {IDLE, ARMED, COPY} state_t;

  state_t             state, state_nx;
  logic [5:0]         cnt;
  logic               pend;
  logic [N-1:0][7:0]  sxs, sys;
  logic [N-1:0][5:0]  spath;
  logic               last;
  logic               wr_pt, wr_path;

  assign pt_ready   = (state != COPY);
  assign path_ready = (state != COPY);
  assign busy       = (state == COPY);
  assign last       = (state == COPY) && (cnt == 6'(N - 1));
  assign wr_pt      = pt_valid && pt_ready;
  assign wr_path    = path_valid && path_ready;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (commit) state_nx = ARMED;
      ARMED:   if (vsync_start) state_nx = COPY;
      // a commit arriving on the final copy edge is honoured like a pending one
      COPY:    if (last) state_nx = (pend || commit) ? ARMED : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pend      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state <= state_nx;
      done  <= last;
      if (state == ARMED && vsync_start) cnt <= '0;
      else if (state == COPY)            cnt <= cnt + 6'd1;
      if (last)                                pend <= 1'b0;
      else if (state == COPY && commit)        pend <= 1'b1;
      if (last) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) begin
        sxs[i]   <= '0;
        sys[i]   <= '0;
        spath[i] <= 6'(i);
      end
    end else begin
      if (wr_pt) begin
        sxs[pt_idx] <= pt_x;
        sys[pt_idx] <= pt_y;
      end
      if (wr_path) spath[path_pos] <= path_node;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) begin
        xs[i]   <= '0;
        ys[i]   <= '0;
        path[i] <= 6'(i);
      end
    end else if (state == COPY) begin
      xs[cnt]   <= sxs[cnt];
      ys[cnt]   <= sys[cnt];
      path[cnt] <= spath[cnt];
    end
  end

endmodule

// File: tb/tb_graph_update_ctrl.sv
// Bench for graph_update_ctrl: table of shadow writes checked after a copy,
// plus hand sequences for arming, pending commits, held writes and reset.
module tb_graph_update_ctrl;

  typedef logic [63:0][7:0] arr8_t;
  typedef logic [63:0][5:0] arr6_t;

  typedef struct {
    logic       do_pt;
    logic [5:0] idx;
    logic [7:0] x, y;
    logic       do_path;
    logic [5:0] pos, node;
    logic [7:0] ex, ey;
    logic [5:0] en;
  } vec_t;

  typedef struct {
    arr8_t       x, y;
    arr6_t       p;
    logic [15:0] fc;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst, vsync_start, commit;
  logic        pt_valid, pt_ready, path_valid, path_ready;
  logic [5:0]  pt_idx, path_pos, path_node;
  logic [7:0]  pt_x, pt_y;
  arr8_t       xs, ys;
  arr6_t       path;
  logic        busy, done;
  logic [15:0] frame_cnt;

  graph_update_ctrl #(.N(64)) dut (
    .clk(clk), .rst(rst), .vsync_start(vsync_start), .commit(commit),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_idx(pt_idx), .pt_x(pt_x), .pt_y(pt_y),
    .path_valid(path_valid), .path_ready(path_ready), .path_pos(path_pos), .path_node(path_node),
    .xs(xs), .ys(ys), .path(path), .busy(busy), .done(done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  arr8_t       m_x, m_y, d_x, d_y;
  arr6_t       m_p, d_p, ident;
  logic [15:0] exp_fc;
  frame_t      sbq[$];
  vec_t        vt[7];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_x = '0;
    m_y = '0;
    for (int i = 0; i < 64; i++) m_p[i] = 6'(i);
    ident  = m_p;
    d_x    = m_x;
    d_y    = m_y;
    d_p    = m_p;
    exp_fc = '0;
    sbq.delete();
  endtask

  task automatic write_vec(input vec_t v);
    pt_valid   = v.do_pt;
    pt_idx     = v.idx;
    pt_x       = v.x;
    pt_y       = v.y;
    path_valid = v.do_path;
    path_pos   = v.pos;
    path_node  = v.node;
    tick();
    pt_valid   = 1'b0;
    path_valid = 1'b0;
    if (v.do_pt) begin
      m_x[v.idx] = v.x;
      m_y[v.idx] = v.y;
    end
    if (v.do_path) m_p[v.pos] = v.node;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  // Starts a copy from ARMED, optionally pulses commit mid-copy and/or holds a
  // point write across the copy, then checks timing and the published frame.
  task automatic run_copy(input int commit_at, input bit hold_pt,
                          input logic [5:0] hidx, input logic [7:0] hx, input logic [7:0] hy);
    frame_t f;
    int n, nlow, ndone;
    vsync_start = 1'b1;
    tick();
    vsync_start = 1'b0;
    f.x = m_x; f.y = m_y; f.p = m_p; f.fc = exp_fc + 16'd1;
    sbq.push_back(f);
    exp_fc = f.fc;
    if (hold_pt) begin
      pt_valid = 1'b1; pt_idx = hidx; pt_x = hx; pt_y = hy;
    end
    n = 0; nlow = 0; ndone = 0;
    while (busy === 1'b1 && n < 200) begin
      if (pt_ready === 1'b0) nlow++;
      if (done === 1'b1) ndone++;
      commit = (n == commit_at);
      tick();
      n++;
    end
    commit = 1'b0;
    check("busy_cycles", 512'(n), 512'(64));
    check("done_during_copy", 512'(ndone), 512'(0));
    check("done_pulse", 512'(done), 512'(1));
    if (hold_pt) begin
      check("pt_ready_low_cycles", 512'(nlow), 512'(64));
      check("pt_ready_after_copy", 512'(pt_ready), 512'(1));
    end
    tick();
    if (hold_pt) begin
      pt_valid = 1'b0;
      m_x[hidx] = hx;
      m_y[hidx] = hy;
    end
    check("done_single", 512'(done), 512'(0));
    if (sbq.size() == 0) begin
      check("scoreboard_empty", 512'(0), 512'(1));
    end else begin
      f = sbq.pop_front();
      d_x = f.x; d_y = f.y; d_p = f.p;
      check("frame_xs", 512'(xs), 512'(f.x));
      check("frame_ys", 512'(ys), 512'(f.y));
      check("frame_path", 512'(path), 512'(f.p));
      check("frame_cnt", 512'(frame_cnt), 512'(f.fc));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    vec_t w;
    rst = 1'b1; vsync_start = 1'b0; commit = 1'b0;
    pt_valid = 1'b0; path_valid = 1'b0;
    pt_idx = '0; pt_x = '0; pt_y = '0; path_pos = '0; path_node = '0;
    model_reset();

    vt[0] = '{1'b1, 6'd5,  8'h20, 8'h1B, 1'b1, 6'd3,  6'd9,  8'h20, 8'h1B, 6'd9};
    vt[1] = '{1'b1, 6'd0,  8'hFF, 8'h01, 1'b1, 6'd0,  6'd63, 8'hFF, 8'h01, 6'd63};
    vt[2] = '{1'b1, 6'd63, 8'hAA, 8'h55, 1'b1, 6'd63, 6'd0,  8'hAA, 8'h55, 6'd0};
    vt[3] = '{1'b1, 6'd10, 8'h11, 8'h22, 1'b1, 6'd10, 6'd10, 8'h33, 8'h44, 6'd12};
    vt[4] = '{1'b1, 6'd10, 8'h33, 8'h44, 1'b1, 6'd10, 6'd12, 8'h33, 8'h44, 6'd12};
    vt[5] = '{1'b1, 6'd40, 8'h7F, 8'h80, 1'b1, 6'd40, 6'd1,  8'h7F, 8'h80, 6'd1};
    vt[6] = '{1'b1, 6'd41, 8'h01, 8'h02, 1'b1, 6'd41, 6'd1,  8'h01, 8'h02, 6'd1};

    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    tick();
    check("rst_xs", 512'(xs), 512'(0));
    check("rst_ys", 512'(ys), 512'(0));
    check("rst_path", 512'(path), 512'(ident));
    check("rst_busy", 512'(busy), 512'(0));
    check("rst_frame_cnt", 512'(frame_cnt), 512'(0));
    check("rst_pt_ready", 512'(pt_ready), 512'(1));
    check("rst_path_ready", 512'(path_ready), 512'(1));
    check("rst_done", 512'(done), 512'(0));

    for (int i = 0; i < 7; i++) write_vec(vt[i]);
    do_commit();
    run_copy(-1, 1'b0, '0, '0, '0);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("vec%0d_x", i), 512'(xs[vt[i].idx]), 512'(vt[i].ex));
      check($sformatf("vec%0d_y", i), 512'(ys[vt[i].idx]), 512'(vt[i].ey));
      check($sformatf("vec%0d_path", i), 512'(path[vt[i].pos]), 512'(vt[i].en));
    end

    // writes and vsync without commit leave the display alone
    w = '{1'b1, 6'd1, 8'h5A, 8'hA5, 1'b1, 6'd2, 6'd50, 8'h00, 8'h00, 6'd0};
    write_vec(w);
    vsync_start = 1'b1;
    tick();
    vsync_start = 1'b0;
    nb = 0;
    repeat (6) begin
      if (busy !== 1'b0) nb++;
      tick();
    end
    check("no_commit_busy", 512'(nb), 512'(0));
    check("no_commit_xs", 512'(xs), 512'(d_x));
    check("no_commit_path", 512'(path), 512'(d_p));

    // commit and vsync together only arm
    commit = 1'b1; vsync_start = 1'b1;
    tick();
    commit = 1'b0; vsync_start = 1'b0;
    nb = 0;
    repeat (4) begin
      if (busy !== 1'b0) nb++;
      tick();
    end
    check("same_cycle_arm_only", 512'(nb), 512'(0));
    run_copy(-1, 1'b0, '0, '0, '0);

    // commit mid-copy re-arms; next vsync runs another copy with a held write
    do_commit();
    run_copy(20, 1'b0, '0, '0, '0);
    nb = 0;
    repeat (3) begin
      if (busy !== 1'b0) nb++;
      tick();
    end
    check("pend_waits_vsync", 512'(nb), 512'(0));
    run_copy(-1, 1'b1, 6'd7, 8'h77, 8'h66);
    do_commit();
    run_copy(-1, 1'b0, '0, '0, '0);
    check("held_write_x", 512'(xs[7]), 512'(8'h77));

    // reset in the middle of a copy
    w = '{1'b1, 6'd20, 8'h99, 8'h88, 1'b0, 6'd0, 6'd0, 8'h00, 8'h00, 6'd0};
    write_vec(w);
    do_commit();
    vsync_start = 1'b1;
    tick();
    vsync_start = 1'b0;
    repeat (30) tick();
    check("mid_copy_busy", 512'(busy), 512'(1));
    rst = 1'b1;
    #1;
    check("abort_busy", 512'(busy), 512'(0));
    check("abort_frame_cnt", 512'(frame_cnt), 512'(0));
    check("abort_xs", 512'(xs), 512'(0));
    check("abort_ys", 512'(ys), 512'(0));
    check("abort_path", 512'(path), 512'(ident));
    #2 rst = 1'b0;
    model_reset();
    tick();
    check("post_rst_pt_ready", 512'(pt_ready), 512'(1));
    check("post_rst_xs", 512'(xs), 512'(0));
    do_commit();
    run_copy(-1, 1'b0, '0, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
